// File: rtl/mux_scan_n.sv
// N-channel, W-bit registered multiplexer with manual select and round-robin auto-scan.
// Define MUX_SCAN_MASK_EN to add the per-channel enable mask port ena_mask.
module mux_scan_n #(
  parameter  int N     = 8,
  parameter  int W     = 1,
  parameter  int DWELL = 1,
  localparam int SELW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N*W-1:0]  d,
  input  logic [SELW-1:0] sel,
  input  logic            auto,
  input  logic            hold,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]    ena_mask,
`endif
  output logic [W-1:0]    o,
  output logic [SELW-1:0] ch,
  output logic            stb
);

  localparam int CW = $clog2(DWELL) + 1;

  typedef enum logic {MAN, SCAN} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q, cnt_d, cntCur;
  logic [SELW-1:0] ch_q, nxt_d, adv, cand, srcCh;
  logic [W-1:0]    o_q, o_d;
  logic            stb_q;
  logic            advFound;
  logic [N-1:0]    en;

`ifdef MUX_SCAN_MASK_EN
  assign en = ena_mask;
`else
  assign en = '1;
`endif

  // Next enabled channel in wrap order, searching at most N-1 steps past ch.
  always_comb begin
    adv      = ch_q;
    advFound = 1'b0;
    cand     = ch_q;
    for (int i = 1; i < N; i++) begin
      cand = (cand == SELW'(N - 1)) ? '0 : cand + SELW'(1);
      if (!advFound && en[cand]) begin
        adv      = cand;
        advFound = 1'b1;
      end
    end
  end

  always_comb begin
    nxt_d  = ch_q;
    cnt_d  = cnt_q;
    cntCur = (state_q == SCAN) ? cnt_q : '0;
    if (auto) begin
      if (cntCur == CW'(DWELL - 1)) begin
        cnt_d = '0;
        nxt_d = adv;
      end else begin
        cnt_d = cntCur + CW'(1);
      end
    end else begin
      cnt_d = '0;
      if (int'(sel) < N) begin
        nxt_d = sel;
      end
    end
  end

  // While held, o keeps following the live data of the frozen channel.
  assign srcCh = hold ? ch_q : nxt_d;

  always_comb begin
    o_d = '0;
    for (int k = 0; k < N; k++) begin
      if (SELW'(k) == srcCh && en[k]) begin
        o_d = d[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= MAN;
      cnt_q   <= '0;
      ch_q    <= '0;
      o_q     <= '0;
      stb_q   <= 1'b0;
    end else if (hold) begin
      o_q   <= o_d;
      stb_q <= 1'b0;
    end else begin
      state_q <= auto ? SCAN : MAN;
      cnt_q   <= cnt_d;
      ch_q    <= nxt_d;
      o_q     <= o_d;
      stb_q   <= (nxt_d != ch_q);
    end
  end

  assign o   = o_q;
  assign ch  = ch_q;
  assign stb = stb_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n: two instances (N=8/W=1/DWELL=1 and N=5/W=4/DWELL=3)
// checked every cycle against a behavioural model; mask tests run when MUX_SCAN_MASK_EN is defined.
module tb_mux_scan_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  logic [7:0]  dA;
  logic [2:0]  selA;
  logic        autoA, holdA;
  logic [7:0]  maskA;
  logic [0:0]  oA;
  logic [2:0]  chA;
  logic        stbA;

  logic [19:0] dB;
  logic [2:0]  selB;
  logic        autoB, holdB;
  logic [4:0]  maskB;
  logic [3:0]  oB;
  logic [2:0]  chB;
  logic        stbB;

  int checks = 0;
  int errors = 0;
  int mChA = 0, mCntA = 0, mChB = 0, mCntB = 0;

  typedef struct {
    int o;
    int ch;
    int stb;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];

  mux_scan_n #(.N(8), .W(1), .DWELL(1)) dutA (
    .clk(clk), .rstn(rstn), .d(dA), .sel(selA), .auto(autoA), .hold(holdA),
`ifdef MUX_SCAN_MASK_EN
    .ena_mask(maskA),
`endif
    .o(oA), .ch(chA), .stb(stbA)
  );

  mux_scan_n #(.N(5), .W(4), .DWELL(3)) dutB (
    .clk(clk), .rstn(rstn), .d(dB), .sel(selB), .auto(autoB), .hold(holdB),
`ifdef MUX_SCAN_MASK_EN
    .ena_mask(maskB),
`endif
    .o(oB), .ch(chB), .stb(stbB)
  );

  task automatic checkOutput(input string tag, input integer actual, input integer expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Behavioural reference: one clock edge of the mux, in plain integer arithmetic.
  task automatic modelStep(input int n, input int w, input int dwell, input logic rstnv,
                           input logic [63:0] dv, input int selv, input logic autov,
                           input logic holdv, input logic [7:0] maskv,
                           input int chIn, input int cntIn,
                           output int chOut, output int cntOut, output int oOut, output int stbOut);
    int nxt;
    chOut  = chIn;
    cntOut = cntIn;
    oOut   = 0;
    stbOut = 0;
    nxt    = chIn;
    if (!rstnv) begin
      chOut  = 0;
      cntOut = 0;
      return;
    end
    if (holdv) begin
      oOut = maskv[chIn] ? int'((dv >> (chIn * w)) & ((64'd1 << w) - 1)) : 0;
      return;
    end
    if (autov) begin
      if (cntIn == dwell - 1) begin
        cntOut = 0;
        for (int i = 1; i < n; i++) begin
          if (maskv[(chIn + i) % n]) begin
            nxt = (chIn + i) % n;
            break;
          end
        end
      end else begin
        cntOut = cntIn + 1;
      end
    end else begin
      cntOut = 0;
      if (selv < n) nxt = selv;
    end
    oOut   = maskv[nxt] ? int'((dv >> (nxt * w)) & ((64'd1 << w) - 1)) : 0;
    stbOut = (nxt != chIn) ? 1 : 0;
    chOut  = nxt;
  endtask

  // Push the model's prediction for the coming edge, clock once, then pop and compare.
  task automatic applyStimulus(input string tag);
    int c, n, o, s;
    exp_t e;
    modelStep(8, 1, 1, rstn, 64'(dA), int'(selA), autoA, holdA, maskA, mChA, mCntA, c, n, o, s);
    mChA = c; mCntA = n;
    e.o = o; e.ch = c; e.stb = s;
    qA.push_back(e);
    modelStep(5, 4, 3, rstn, 64'(dB), int'(selB), autoB, holdB, {3'b000, maskB}, mChB, mCntB, c, n, o, s);
    mChB = c; mCntB = n;
    e.o = o; e.ch = c; e.stb = s;
    qB.push_back(e);
    @(posedge clk);
    #1;
    e = qA.pop_front();
    checkOutput({tag, ".A.o"}, integer'(oA), e.o);
    checkOutput({tag, ".A.ch"}, integer'(chA), e.ch);
    checkOutput({tag, ".A.stb"}, integer'(stbA), e.stb);
    e = qB.pop_front();
    checkOutput({tag, ".B.o"}, integer'(oB), e.o);
    checkOutput({tag, ".B.ch"}, integer'(chB), e.ch);
    checkOutput({tag, ".B.stb"}, integer'(stbB), e.stb);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".A.o"}, integer'(oA), 0);
    checkOutput({tag, ".A.ch"}, integer'(chA), 0);
    checkOutput({tag, ".A.stb"}, integer'(stbA), 0);
    checkOutput({tag, ".B.o"}, integer'(oB), 0);
    checkOutput({tag, ".B.ch"}, integer'(chB), 0);
    checkOutput({tag, ".B.stb"}, integer'(stbB), 0);
  endtask

  initial begin
    rstn  = 1'b1;
    dA    = '0; selA = '0; autoA = 1'b0; holdA = 1'b0; maskA = 8'hFF;
    dB    = '0; selB = '0; autoB = 1'b0; holdB = 1'b0; maskB = 5'h1F;

    // Reset asserted before the first edge, held 3 cycles with toggling data.
    #2 rstn = 1'b0;
    #1 checkResetState("rst.assert");
    mChA = 0; mCntA = 0; mChB = 0; mCntB = 0;
    for (int i = 0; i < 3; i++) begin
      dA = 8'($urandom);
      dB = 20'($urandom);
      applyStimulus("rst.hold");
    end
    #2 rstn = 1'b1;
    #1 checkResetState("rst.release");

    // Manual sweep on the 8-channel instance, starting away from ch 0 so every step strobes.
    dA = 8'b1010_0110;
    dB = 20'h4C3A1;
    selA = 3'd7;
    applyStimulus("man.pre");
    for (int s = 0; s < 8; s++) begin
      selA = 3'(s);
      applyStimulus("man.sweep");
    end

    // Scan three steps (7->0->1->2), then hold while auto drops and sel moves to 6.
    autoA = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("scanA");
    holdA = 1'b1; autoA = 1'b0; selA = 3'd6;
    for (int i = 0; i < 4; i++) begin
      dA = 8'($urandom);
      applyStimulus("hold");
    end
    holdA = 1'b0;
    applyStimulus("hold.release");

    // Five-channel scan with dwell 3 through the 4->0 wrap.
    selB = 3'd0;
    applyStimulus("scanB.pre");
    autoB = 1'b1;
    for (int i = 0; i < 17; i++) begin
      dB = 20'($urandom);
      applyStimulus("scanB");
    end

    // Out-of-range select on the five-channel instance.
    autoB = 1'b0; selB = 3'd3;
    applyStimulus("oor.pre");
    selB = 3'd7;
    for (int i = 0; i < 2; i++) begin
      dB = 20'($urandom);
      applyStimulus("oor");
    end

`ifdef MUX_SCAN_MASK_EN
    dA = 8'hFF;
    maskA = 8'b1000_0101; autoA = 1'b0; selA = 3'd0;
    applyStimulus("mask.pre");
    autoA = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus("mask.scan");
    maskA = 8'h00;
    for (int i = 0; i < 3; i++) applyStimulus("mask.none");
    maskA = 8'hFD; autoA = 1'b0; selA = 3'd1;
    applyStimulus("mask.man");
    maskA = 8'hFF;
`endif

    // Random traffic on both instances.
    for (int i = 0; i < 60; i++) begin
      dA = 8'($urandom);
      dB = 20'($urandom);
      selA = 3'($urandom);
      selB = 3'($urandom);
      holdA = ($urandom_range(0, 3) == 0);
      holdB = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) autoA = ~autoA;
      if ($urandom_range(0, 4) == 0) autoB = ~autoB;
`ifdef MUX_SCAN_MASK_EN
      maskA = 8'($urandom);
      maskB = 5'($urandom);
`endif
      applyStimulus("rand");
    end

    // Reset asserted mid-scan must clear outputs without waiting for an edge.
    holdA = 1'b0; holdB = 1'b0; autoA = 1'b1; autoB = 1'b1;
    maskA = 8'hFF; maskB = 5'h1F;
    for (int i = 0; i < 4; i++) applyStimulus("prerst");
    #2 rstn = 1'b0;
    #1 checkResetState("rst.mid");
    mChA = 0; mCntA = 0; mChB = 0; mCntB = 0;
    applyStimulus("rst.mid.hold");
    #2 rstn = 1'b1;
    #1 checkResetState("rst.mid.release");
    for (int i = 0; i < 4; i++) applyStimulus("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
